// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues encoded ops to the ripple-carry ALU, waits a
// settle window, then returns registered result/flags on a response channel.
module alu_op_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned TAG_W         = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   input  logic [TAG_W-1:0] req_tag,
   output logic [31:0]      alu_src1,
   output logic [31:0]      alu_src2,
   output logic [3:0]       alu_ctrl,
   input  logic [31:0]      alu_result,
   input  logic             alu_zero,
   input  logic             alu_cout,
   input  logic             alu_overflow,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_result,
   output logic [2:0]       rsp_flags,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_err,
   output logic             busy,
   output logic [15:0]      op_count
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [31:0]      src1_q, src1_d;
   logic [31:0]      src2_q, src2_d;
   logic [3:0]       ctrl_q, ctrl_d;
   logic             logic_op_q, logic_op_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [31:0]      result_q, result_d;
   logic [2:0]       flags_q, flags_d;
   logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
   logic             err_q, err_d;
   logic [15:0]      count_q, count_d;
   logic             accept;
   logic             reserved;
   logic [3:0]       enc_ctrl;

   always_comb begin
      enc_ctrl = 4'b0000;
      unique case (req_op)
         3'b000:  enc_ctrl = 4'b0000;
         3'b001:  enc_ctrl = 4'b0001;
         3'b010:  enc_ctrl = 4'b0010;
         3'b011:  enc_ctrl = 4'b0110;
         3'b100:  enc_ctrl = 4'b1100;
         3'b101:  enc_ctrl = 4'b1101;
         3'b110:  enc_ctrl = 4'b0111;
         default: enc_ctrl = 4'b0000;
      endcase
   end

   assign req_ready = (state_q == IDLE) ||
                      ((state_q == RESP) && rsp_ready);
   assign accept    = req_valid && req_ready;
   assign reserved  = (req_op == 3'b111);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      src1_d     = src1_q;
      src2_d     = src2_q;
      ctrl_d     = ctrl_q;
      logic_op_d = logic_op_q;
      tag_d      = tag_q;
      result_d   = result_q;
      flags_d    = flags_q;
      rsp_tag_d  = rsp_tag_q;
      err_d      = err_q;
      count_d    = count_q;

      unique case (state_q)
         EXEC: begin
            if (cnt_q == 4'd0) begin
               // carry/overflow are meaningless for bitwise ops
               result_d  = alu_result;
               flags_d   = {alu_overflow & ~logic_op_q,
                            alu_cout & ~logic_op_q,
                            alu_zero};
               err_d     = 1'b0;
               rsp_tag_d = tag_q;
               state_d   = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               count_d = count_q + 16'd1;
               state_d = IDLE;
            end
         end
         default: ;
      endcase

      if (accept) begin
         src1_d     = req_a;
         src2_d     = req_b;
         ctrl_d     = enc_ctrl;
         tag_d      = req_tag;
         logic_op_d = ~req_op[1];
         if (reserved) begin
            result_d  = 32'd0;
            flags_d   = 3'b000;
            err_d     = 1'b1;
            rsp_tag_d = req_tag;
            state_d   = RESP;
         end else begin
            cnt_d   = SETTLE_LOAD;
            state_d = EXEC;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         src1_q     <= 32'd0;
         src2_q     <= 32'd0;
         ctrl_q     <= 4'd0;
         logic_op_q <= 1'b0;
         tag_q      <= '0;
         result_q   <= 32'd0;
         flags_q    <= 3'd0;
         rsp_tag_q  <= '0;
         err_q      <= 1'b0;
         count_q    <= 16'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         src1_q     <= src1_d;
         src2_q     <= src2_d;
         ctrl_q     <= ctrl_d;
         logic_op_q <= logic_op_d;
         tag_q      <= tag_d;
         result_q   <= result_d;
         flags_q    <= flags_d;
         rsp_tag_q  <= rsp_tag_d;
         err_q      <= err_d;
         count_q    <= count_d;
      end
   end

   assign alu_src1   = src1_q;
   assign alu_src2   = src2_q;
   assign alu_ctrl   = ctrl_q;
   assign rsp_valid  = (state_q == RESP);
   assign rsp_result = result_q;
   assign rsp_flags  = flags_q;
   assign rsp_tag    = rsp_tag_q;
   assign rsp_err    = err_q;
   assign busy       = (state_q != IDLE);
   assign op_count   = count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed scenarios against a behavioural ALU model.
module tb_alu_op_sequencer;

   localparam int S  = 2;
   localparam int TW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic [2:0]    req_op;
   logic [31:0]   req_a;
   logic [31:0]   req_b;
   logic [TW-1:0] req_tag;
   logic [31:0]   alu_src1;
   logic [31:0]   alu_src2;
   logic [3:0]    alu_ctrl;
   logic [31:0]   alu_result;
   logic          alu_zero;
   logic          alu_cout;
   logic          alu_overflow;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [31:0]   rsp_result;
   logic [2:0]    rsp_flags;
   logic [TW-1:0] rsp_tag;
   logic          rsp_err;
   logic          busy;
   logic [15:0]   op_count;

   int          total = 0;
   int          bad   = 0;
   logic [15:0] exp_cnt;

   always #5 clk = ~clk;

   alu_op_sequencer #(
      .SETTLE_CYCLES(S),
      .TAG_W(TW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_op(req_op),
      .req_a(req_a),
      .req_b(req_b),
      .req_tag(req_tag),
      .alu_src1(alu_src1),
      .alu_src2(alu_src2),
      .alu_ctrl(alu_ctrl),
      .alu_result(alu_result),
      .alu_zero(alu_zero),
      .alu_cout(alu_cout),
      .alu_overflow(alu_overflow),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_result(rsp_result),
      .rsp_flags(rsp_flags),
      .rsp_tag(rsp_tag),
      .rsp_err(rsp_err),
      .busy(busy),
      .op_count(op_count)
   );

   // ALU model; bitwise ops report junk carry/overflow (both 1)
   logic [32:0] add_s;
   logic [32:0] sub_s;
   logic        add_v;
   logic        sub_v;
   always_comb begin
      add_s = {1'b0, alu_src1} + {1'b0, alu_src2};
      sub_s = {1'b0, alu_src1} + {1'b0, ~alu_src2} + 33'd1;
      add_v = (alu_src1[31] == alu_src2[31]) && (add_s[31] != alu_src1[31]);
      sub_v = (alu_src1[31] != alu_src2[31]) && (sub_s[31] != alu_src1[31]);
      alu_result   = 32'd0;
      alu_cout     = 1'b1;
      alu_overflow = 1'b1;
      case (alu_ctrl)
         4'b0000: alu_result = alu_src1 & alu_src2;
         4'b0001: alu_result = alu_src1 | alu_src2;
         4'b1100: alu_result = ~(alu_src1 | alu_src2);
         4'b1101: alu_result = ~(alu_src1 & alu_src2);
         4'b0010: begin
            alu_result   = add_s[31:0];
            alu_cout     = add_s[32];
            alu_overflow = add_v;
         end
         4'b0110: begin
            alu_result   = sub_s[31:0];
            alu_cout     = sub_s[32];
            alu_overflow = sub_v;
         end
         4'b0111: begin
            alu_result   = {31'd0, sub_s[31] ^ sub_v};
            alu_cout     = sub_s[32];
            alu_overflow = sub_v;
         end
         default: alu_result = 32'd0;
      endcase
      alu_zero = (alu_result == 32'd0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [TW-1:0] tag);
      req_op    = op;
      req_a     = a;
      req_b     = b;
      req_tag   = tag;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int n);
      n = 0;
      while (!rsp_valid && n < 50) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      exp_cnt = 16'd0;
      total++;
      if ({busy, req_ready, rsp_valid, rsp_err} !== 4'b0100) begin
         bad++;
         $display("FAIL reset_ctl: got %b want 0100",
                  {busy, req_ready, rsp_valid, rsp_err});
      end
      total++;
      if ({alu_ctrl, alu_src1, alu_src2, op_count} !== 84'd0) begin
         bad++;
         $display("FAIL reset_data: got ctrl=%h s1=%h s2=%h cnt=%h want 0",
                  alu_ctrl, alu_src1, alu_src2, op_count);
      end
      total++;
      if ({rsp_result, rsp_flags, rsp_tag} !== 39'd0) begin
         bad++;
         $display("FAIL reset_rsp: got %h %b %h want 0",
                  rsp_result, rsp_flags, rsp_tag);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_add();
      int n;
      issue(3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 4'd3);
      total++;
      if ({busy, rsp_valid, alu_ctrl} !== 6'b10_0010) begin
         bad++;
         $display("FAIL add_accept: got %b want 100010",
                  {busy, rsp_valid, alu_ctrl});
      end
      wait_rsp(n);
      total++;
      if (n !== S) begin
         bad++;
         $display("FAIL add_latency: got %0d want %0d", n, S);
      end
      total++;
      if ({rsp_result, rsp_flags, rsp_tag, rsp_err} !==
          {32'h8000_0000, 3'b100, 4'd3, 1'b0}) begin
         bad++;
         $display("FAIL add_rsp: got %h %b %h %b want 80000000 100 3 0",
                  rsp_result, rsp_flags, rsp_tag, rsp_err);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      exp_cnt++;
      total++;
      if ({busy, rsp_valid, req_ready, op_count} !== {3'b001, exp_cnt}) begin
         bad++;
         $display("FAIL add_done: got %b cnt=%h want 001 cnt=%h",
                  {busy, rsp_valid, req_ready}, op_count, exp_cnt);
      end
   endtask

   task automatic test_sub();
      int n;
      issue(3'b011, 32'd5, 32'd5, 4'd1);
      total++;
      if (alu_ctrl !== 4'b0110) begin
         bad++;
         $display("FAIL sub_ctrl0: got %b want 0110", alu_ctrl);
      end
      tick();
      total++;
      if ({alu_ctrl, rsp_valid, alu_src1, alu_src2} !==
          {4'b0110, 1'b0, 32'd5, 32'd5}) begin
         bad++;
         $display("FAIL sub_hold: got ctrl=%b v=%b s1=%h s2=%h",
                  alu_ctrl, rsp_valid, alu_src1, alu_src2);
      end
      wait_rsp(n);
      total++;
      if ({rsp_result, rsp_flags} !== {32'd0, 3'b011}) begin
         bad++;
         $display("FAIL sub_rsp: got %h %b want 0 011",
                  rsp_result, rsp_flags);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      exp_cnt++;
   endtask

   task automatic test_logic_mask();
      int n;
      logic [2:0]  ops [3];
      logic [31:0] as  [3];
      logic [31:0] bs  [3];
      logic [31:0] rs  [3];
      logic [2:0]  fs  [3];
      ops[0] = 3'b100; as[0] = 32'hFFFF_0000; bs[0] = 32'h0000_FFFF;
      rs[0]  = 32'd0;  fs[0] = 3'b001;
      ops[1] = 3'b101; as[1] = 32'hFFFF_FFFF; bs[1] = 32'hFFFF_FFFF;
      rs[1]  = 32'd0;  fs[1] = 3'b001;
      ops[2] = 3'b001; as[2] = 32'h0000_00F0; bs[2] = 32'h0000_000F;
      rs[2]  = 32'h0000_00FF; fs[2] = 3'b000;
      for (int i = 0; i < 3; i++) begin
         issue(ops[i], as[i], bs[i], 4'(i + 8));
         wait_rsp(n);
         total++;
         if ({rsp_result, rsp_flags, rsp_tag} !==
             {rs[i], fs[i], 4'(i + 8)}) begin
            bad++;
            $display("FAIL logic_%0d: got %h %b %h want %h %b %h", i,
                     rsp_result, rsp_flags, rsp_tag, rs[i], fs[i], i + 8);
         end
         rsp_ready = 1'b1;
         tick();
         rsp_ready = 1'b0;
         exp_cnt++;
      end
      total++;
      if (op_count !== exp_cnt) begin
         bad++;
         $display("FAIL logic_count: got %h want %h", op_count, exp_cnt);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      issue(3'b010, 32'd10, 32'd20, 4'd5);
      wait_rsp(n);
      req_op    = 3'b000;
      req_a     = 32'hF0F0_F0F0;
      req_b     = 32'hFF00_FF00;
      req_tag   = 4'd6;
      req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if ({rsp_valid, req_ready, rsp_result, rsp_tag, alu_ctrl} !==
             {1'b1, 1'b0, 32'd30, 4'd5, 4'b0010}) begin
            bad++;
            $display("FAIL bp_hold_%0d: got v=%b rdy=%b %h %h ctrl=%b", i,
                     rsp_valid, req_ready, rsp_result, rsp_tag, alu_ctrl);
         end
      end
      total++;
      if (op_count !== exp_cnt) begin
         bad++;
         $display("FAIL bp_count: got %h want %h", op_count, exp_cnt);
      end
      rsp_ready = 1'b1;
      tick();
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      exp_cnt++;
      total++;
      if ({busy, rsp_valid, alu_ctrl, alu_src1, op_count} !==
          {2'b10, 4'b0000, 32'hF0F0_F0F0, exp_cnt}) begin
         bad++;
         $display("FAIL b2b_accept: got %b ctrl=%b s1=%h cnt=%h",
                  {busy, rsp_valid}, alu_ctrl, alu_src1, op_count);
      end
      wait_rsp(n);
      total++;
      if (n !== S) begin
         bad++;
         $display("FAIL b2b_latency: got %0d want %0d", n, S);
      end
      total++;
      if ({rsp_result, rsp_flags, rsp_tag} !==
          {32'hF000_F000, 3'b000, 4'd6}) begin
         bad++;
         $display("FAIL b2b_rsp: got %h %b %h want f000f000 000 6",
                  rsp_result, rsp_flags, rsp_tag);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      exp_cnt++;
   endtask

   task automatic test_slt();
      int n;
      issue(3'b110, 32'hFFFF_FFFF, 32'd1, 4'd2);
      wait_rsp(n);
      total++;
      if ({rsp_result, rsp_flags, alu_ctrl} !== {32'd1, 3'b010, 4'b0111}) begin
         bad++;
         $display("FAIL slt_rsp: got %h %b ctrl=%b want 1 010 0111",
                  rsp_result, rsp_flags, alu_ctrl);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      exp_cnt++;
   endtask

   task automatic test_reserved();
      issue(3'b111, 32'd1, 32'd2, 4'd9);
      total++;
      if ({rsp_valid, rsp_err, rsp_result, rsp_flags, rsp_tag, alu_ctrl} !==
          {2'b11, 32'd0, 3'b000, 4'd9, 4'b0000}) begin
         bad++;
         $display("FAIL reserved: got v=%b e=%b %h %b %h ctrl=%b",
                  rsp_valid, rsp_err, rsp_result, rsp_flags, rsp_tag,
                  alu_ctrl);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      exp_cnt++;
      total++;
      if ({busy, op_count} !== {1'b0, exp_cnt}) begin
         bad++;
         $display("FAIL reserved_done: got busy=%b cnt=%h want 0 %h",
                  busy, op_count, exp_cnt);
      end
   endtask

   task automatic test_reset_mid_exec();
      issue(3'b010, 32'd7, 32'd8, 4'd4);
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL rme_busy: got %b want 1", busy);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_cnt = 16'd0;
      total++;
      if ({busy, req_ready, rsp_valid, alu_ctrl, op_count} !==
          {3'b010, 4'b0000, 16'd0}) begin
         bad++;
         $display("FAIL rme_state: got %b ctrl=%b cnt=%h",
                  {busy, req_ready, rsp_valid}, alu_ctrl, op_count);
      end
      tick();
      total++;
      if ({busy, rsp_valid} !== 2'b00) begin
         bad++;
         $display("FAIL rme_idle: got %b want 00", {busy, rsp_valid});
      end
   endtask

   task automatic test_count_wrap();
      req_op    = 3'b111;
      req_a     = 32'd0;
      req_b     = 32'd0;
      req_tag   = 4'd0;
      req_valid = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 65536; i++) tick();
      total++;
      if ({rsp_valid, op_count} !== {1'b1, 16'hFFFF}) begin
         bad++;
         $display("FAIL wrap_pre: got v=%b cnt=%h want 1 ffff",
                  rsp_valid, op_count);
      end
      req_valid = 1'b0;
      tick();
      rsp_ready = 1'b0;
      total++;
      if ({busy, op_count} !== {1'b0, 16'h0000}) begin
         bad++;
         $display("FAIL wrap_post: got busy=%b cnt=%h want 0 0000",
                  busy, op_count);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_op    = 3'b000;
      req_a     = 32'd0;
      req_b     = 32'd0;
      req_tag   = '0;
      rsp_ready = 1'b0;
      exp_cnt   = 16'd0;
      test_reset();
      test_add();
      test_sub();
      test_logic_mask();
      test_back_to_back();
      test_slt();
      test_reserved();
      test_reset_mid_exec();
      test_count_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Sequential front-end that drives the 32-bit ripple-carry ALU. It is the producer side of the ALU's src1/src2/ALU_control interface.
- Accepts abstract operation requests over a valid/ready handshake and encodes each into the 4-bit ALU control code.
- Holds the operands stable for a programmable settle window, then captures result and flags into a registered response with its own valid/ready handshake.
- Sits between the datapath issue logic and the ALU.

Parameters:
- SETTLE_CYCLES, 2: cycles operands and control are held before capture (ripple settle time). Legal range 1..15.
- TAG_W, 4: width of the request/response tag.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  sequencer can accept a request
- req_op  input  3  operation: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 NOR, 101 NAND, 110 SLT, 111 reserved
- req_a  input  32  operand A
- req_b  input  32  operand B
- req_tag  input  TAG_W  request tag, returned unchanged
- alu_src1  output  32  to ALU src1
- alu_src2  output  32  to ALU src2
- alu_ctrl  output  4  to ALU_control
- alu_result  input  32  from ALU result
- alu_zero  input  1  from ALU zero
- alu_cout  input  1  from ALU cout
- alu_overflow  input  1  from ALU overflow
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_result  output  32  captured result
- rsp_flags  output  3  {overflow, cout, zero}
- rsp_tag  output  TAG_W  tag of the completed request
- rsp_err  output  1  reserved opcode was issued
- busy  output  1  FSM not in IDLE
- op_count  output  16  completed responses, counted at the rsp handshake

Behaviour:
- Reset (rst_n low at a rising edge):
  - FSM goes to IDLE.
  - All outputs go to 0, except req_ready, which goes to 1.
  - alu_ctrl=0000, alu_src1/alu_src2=0, settle counter=0, op_count=0.
  - Reset overrides everything, including mid-EXEC and mid-RESP. Any pending response is dropped and op_count is not incremented.
- Opcode encoding into alu_ctrl, registered at accept:
  - AND 0000, OR 0001, ADD 0010, SUB 0110, NOR 1100, NAND 1101, SLT 0111.
  - Reserved opcode 111: alu_ctrl held at 0000.
- States: IDLE, EXEC, RESP.
  - In IDLE, req_ready is 1.
- IDLE, on req_valid&&req_ready:
  - Register operands to alu_src1/alu_src2, register the encoded alu_ctrl, latch the tag.
  - For opcodes 000..110: go to EXEC and load the counter with SETTLE_CYCLES-1.
  - For reserved 111: go directly to RESP with rsp_result=0, rsp_flags=000, rsp_err=1. No settle wait.
- EXEC:
  - alu_src1, alu_src2 and alu_ctrl are held constant.
  - The counter decrements each cycle.
  - On the cycle the counter is 0, at that edge: capture alu_result into rsp_result and the flags into rsp_flags, set rsp_err=0, go to RESP.
  - Latency from accept edge to rsp_valid high is SETTLE_CYCLES cycles.
- Flag masking:
  - For logic ops (AND/OR/NOR/NAND), the cout and overflow bits of rsp_flags are forced to 0.
  - zero is always taken from alu_zero.
  - For ADD/SUB/SLT, all three flags are taken raw from the ALU.
- RESP:
  - rsp_valid=1; rsp_result, rsp_flags, rsp_tag and rsp_err are stable until the handshake.
  - On rsp_valid&&rsp_ready: op_count increments, wrapping 0xFFFF->0x0000.
  - req_ready = rsp_ready while in RESP, so back-to-back is possible.
  - If rsp_ready&&req_valid in the same cycle, the new request is accepted at that edge and the FSM goes straight to EXEC, or to RESP for a reserved opcode. rsp_valid deasserts for at least the EXEC window.
  - Handshake without a new request: return to IDLE.
- Inputs while not accepting:
  - req_valid while req_ready=0 is ignored.
  - A requester must hold req_* stable until accepted.
- Backpressure: with rsp_ready=0, the FSM stays in RESP indefinitely. No request is lost, and no response is overwritten.
- Output idle values:
  - alu_src1, alu_src2 and alu_ctrl retain their last value in IDLE.
  - rsp_* retain their last value; rsp_valid=0.
- busy = (state != IDLE).

Test Plan:
- Basic ADD: SETTLE_CYCLES=2, ADD a=0x7FFFFFFF b=0x00000001 tag=3 -> rsp_valid exactly 2 cycles after accept; rsp_result=0x80000000, rsp_flags=100, rsp_tag=3.
- SUB equal operands: SUB a=5 b=5 -> rsp_result=0, flags zero=1, cout=1, overflow=0; alu_ctrl=0110 held through EXEC.
- Logic-op masking: NOR a=0xFFFF0000 b=0x0000FFFF -> rsp_result=0, flags=001 (cout and overflow masked); NAND a=b=0xFFFFFFFF -> rsp_result=0, flags=001.
- Backpressure then back-to-back:
  - rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0.
  - Then rsp_ready=1 with an AND request queued -> op_count +1, AND accepted on the same edge, next rsp_valid after SETTLE_CYCLES.
- Reserved opcode: req_op=111 -> rsp_valid the cycle after accept, rsp_err=1, rsp_result=0, alu_ctrl=0000.
- Reset mid-EXEC: rst_n low during EXEC of ADD -> next cycle busy=0, req_ready=1, rsp_valid=0, op_count=0, alu_ctrl=0000. op_count starting at 0xFFFF plus one completed handshake -> 0x0000.
